// File: rtl/cut_eval_sequencer_pkg.sv
// Shared types and helpers for the exhaustive CUT evaluation sequencer.
// The optional EVAL_MISMATCH_CNT_EN build is handled in the top module.
package cut_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    // Bits needed to hold n-1, never less than one, so a one-cycle settle still gets a counter.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cut_eval_sequencer_settle_timer.sv
// Down-counter that holds a vector for a fixed number of cycles; expire is high once the count reaches zero.
module settle_timer #(
    parameter int              CNT_W    = 1,
    parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    // Load takes priority so a new vector always starts a full settle window.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/cut_eval_sequencer.sv
// Exhaustive sweep of a combinational CUT against a golden model, reporting the first counterexample.
// Define EVAL_MISMATCH_CNT_EN to sweep every vector and count failures on mismatch_cnt.
module cut_eval_sequencer
    import cut_eval_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int N_OUT      = 1,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  cut_in,
    input  logic [N_OUT-1:0] cut_out,
    input  logic [N_OUT-1:0] gold_out,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [N_IN-1:0]  cex_vec,
    output logic [N_IN:0]    vec_cnt
`ifdef EVAL_MISMATCH_CNT_EN
    ,
    output logic [N_IN:0]    mismatch_cnt
`endif
);

    localparam int               CNT_W    = clog2_min1(SETTLE_CYC);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

    state_t state_q, state_d;
    logic   timer_load, timer_en, expire;
    logic   fail, last;

    assign fail = (cut_out != gold_out);
    assign last = &cut_in;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    settle_timer #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (LOAD_VAL)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .en     (timer_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The timer is reloaded whenever a new vector enters SETTLE.
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    timer_load = 1'b1;
                end
            end
            SETTLE: begin
                timer_en = 1'b1;
                if (expire) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
`ifdef EVAL_MISMATCH_CNT_EN
                if (last) begin
                    state_d = DONE;
                end else begin
                    state_d    = SETTLE;
                    timer_load = 1'b1;
                end
`else
                if (fail || last) begin
                    state_d = DONE;
                end else begin
                    state_d    = SETTLE;
                    timer_load = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Results are only cleared by an accepted start, so they survive the return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cut_in   <= '0;
            vec_cnt  <= '0;
            mismatch <= 1'b0;
            cex_vec  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cut_in   <= '0;
                        vec_cnt  <= '0;
                        mismatch <= 1'b0;
                        cex_vec  <= '0;
                    end
                end
                CHECK: begin
                    vec_cnt <= vec_cnt + (N_IN+1)'(1);
                    if (fail) begin
                        mismatch <= 1'b1;
                        if (!mismatch) begin
                            cex_vec <= cut_in;
                        end
                    end
                    if (state_d == SETTLE) begin
                        cut_in <= cut_in + N_IN'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef EVAL_MISMATCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_cnt <= '0;
        end else if ((state_q == IDLE) && start) begin
            mismatch_cnt <= '0;
        end else if ((state_q == CHECK) && fail) begin
            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
        end
    end
`endif

endmodule
